// File: rtl/if_stage_pipe.sv
// if_stage_pipe: instruction fetch stage with the IF/ID pipeline register.
// Owns the PC, presents it to instruction memory, and latches PC and
// instruction into IF/ID. Stall freezes the stage and asks ID/EX for a bubble.
// Flush redirects fetch and squashes IF/ID to a NOP. Stall/flush counters and
// a stuck-stall watchdog are kept alongside.
//
// Handshake: there is no valid/ready pair here. stall is a hold request that
// wins over advance. flush is a redirect that wins over stall. rst wins over
// both and discards them for that edge.
module if_stage_pipe #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013,
    parameter int          CNT_W     = 16,
    parameter int          STALL_MAX = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic [XLEN-1:0]  branch_target,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [XLEN-1:0]  if_id_pc,
    output logic [XLEN-1:0]  if_id_pc_plus4,
    output logic [31:0]      if_id_inst,
    output logic             if_id_valid,
    output logic             id_ex_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             stall_err
);

    // consec must be able to hold STALL_MAX+1, where it saturates.
    localparam int                   CONSEC_W   = $clog2(STALL_MAX + 2);
    localparam logic [CONSEC_W-1:0]  CONSEC_SAT = CONSEC_W'(STALL_MAX + 1);
    localparam logic [CONSEC_W-1:0]  CONSEC_LIM = CONSEC_W'(STALL_MAX);

    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     pc_plus4;
    logic [XLEN-1:0]     redirect_pc;
    logic [CONSEC_W-1:0] consec;
    logic                do_stall;

    // Fetch address and the bubble request are the only combinational outputs.
    always_comb begin
        imem_addr    = pc;
        pc_plus4     = pc + XLEN'(4);
        redirect_pc  = {branch_target[XLEN-1:2], 2'b00};
        do_stall     = stall & ~flush;
        id_ex_bubble = stall & ~flush;
    end

    // PC and IF/ID register: reset > flush > stall > advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= XLEN'(RESET_PC);
            if_id_pc       <= '0;
            if_id_pc_plus4 <= '0;
            if_id_inst     <= NOP_INST;
            if_id_valid    <= 1'b0;
        end else if (flush) begin
            pc          <= redirect_pc;
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            pc             <= pc_plus4;
            if_id_pc       <= pc;
            if_id_pc_plus4 <= pc_plus4;
            if_id_inst     <= imem_rdata;
            if_id_valid    <= 1'b1;
        end
    end

    // Saturating performance counters; a flush cycle never counts as a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (do_stall && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
            if (flush && (flush_count != '1))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

    // Stuck-stall watchdog: count consecutive stalls, flag sticky error
    // once the run length goes past STALL_MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            consec    <= '0;
            stall_err <= 1'b0;
        end else if (do_stall) begin
            if (consec != CONSEC_SAT)
                consec <= consec + CONSEC_W'(1);
            if (consec >= CONSEC_LIM)
                stall_err <= 1'b1;
        end else begin
            consec <= '0;
        end
    end

endmodule

// File: tb/tb_if_stage_pipe.sv
// tb_if_stage_pipe: directed bench for the fetch stage. A second instance with
// 4-bit counters shares all inputs so counter saturation is reachable quickly.
module tb_if_stage_pipe;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic        id_ex_bubble;
    logic [15:0] stall_count;
    logic [15:0] flush_count;
    logic        stall_err;

    logic [31:0] s_imem_addr;
    logic [31:0] s_if_id_pc;
    logic [31:0] s_if_id_pc_plus4;
    logic [31:0] s_if_id_inst;
    logic        s_if_id_valid;
    logic        s_id_ex_bubble;
    logic [3:0]  s_stall_count;
    logic [3:0]  s_flush_count;
    logic        s_stall_err;

    int n_cmp;
    int n_err;

    // ---------------- clock / reset block ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instruction memory model ----------------
    function automatic logic [31:0] inst_at(input logic [31:0] a);
        if (a == 32'h0)      return 32'h00A0_0093;
        else if (a == 32'h4) return 32'h0010_0113;
        else                 return a ^ 32'h5A5A_0000;
    endfunction

    always_comb imem_rdata = inst_at(imem_addr);

    if_stage_pipe dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .branch_target(branch_target), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .if_id_pc(if_id_pc),
        .if_id_pc_plus4(if_id_pc_plus4), .if_id_inst(if_id_inst),
        .if_id_valid(if_id_valid), .id_ex_bubble(id_ex_bubble),
        .stall_count(stall_count), .flush_count(flush_count),
        .stall_err(stall_err)
    );

    if_stage_pipe #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .branch_target(branch_target), .imem_addr(s_imem_addr),
        .imem_rdata(imem_rdata), .if_id_pc(s_if_id_pc),
        .if_id_pc_plus4(s_if_id_pc_plus4), .if_id_inst(s_if_id_inst),
        .if_id_valid(s_if_id_valid), .id_ex_bubble(s_id_ex_bubble),
        .stall_count(s_stall_count), .flush_count(s_flush_count),
        .stall_err(s_stall_err)
    );

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = 32'h0;

        // 1 reset
        tick(); tick();
        chk("rst_addr",   64'(imem_addr),   64'h0);
        chk("rst_inst",   64'(if_id_inst),  64'h13);
        chk("rst_valid",  64'(if_id_valid), 64'h0);
        chk("rst_pc",     64'(if_id_pc),    64'h0);
        chk("rst_scnt",   64'(stall_count), 64'h0);
        chk("rst_fcnt",   64'(flush_count), 64'h0);
        chk("rst_err",    64'(stall_err),   64'h0);
        rst = 1'b0;

        // 2 stream
        tick();
        chk("s0_pc",    64'(if_id_pc),       64'h0);
        chk("s0_inst",  64'(if_id_inst),     64'h00A0_0093);
        chk("s0_p4",    64'(if_id_pc_plus4), 64'h4);
        chk("s0_valid", 64'(if_id_valid),    64'h1);
        chk("s0_addr",  64'(imem_addr),      64'h4);
        tick();
        chk("s1_pc",    64'(if_id_pc),       64'h4);
        chk("s1_inst",  64'(if_id_inst),     64'h0010_0113);
        chk("s1_p4",    64'(if_id_pc_plus4), 64'h8);
        chk("s1_addr",  64'(imem_addr),      64'h8);

        // 3 load-use stall for one cycle at pc=8
        stall = 1'b1;
        #1;
        chk("lu_bubble", 64'(id_ex_bubble), 64'h1);
        tick();
        chk("lu_addr",  64'(imem_addr),   64'h8);
        chk("lu_pc",    64'(if_id_pc),    64'h4);
        chk("lu_inst",  64'(if_id_inst),  64'h0010_0113);
        chk("lu_scnt",  64'(stall_count), 64'h1);
        chk("lu_err",   64'(stall_err),   64'h0);
        stall = 1'b0;
        tick();
        chk("lu_adv_pc",   64'(if_id_pc),   64'h8);
        chk("lu_adv_inst", 64'(if_id_inst), 64'h5A5A_0008);
        chk("lu_adv_addr", 64'(imem_addr),  64'hC);

        // 4 flush and stall together, misaligned target
        stall = 1'b1; flush = 1'b1; branch_target = 32'h103;
        #1;
        chk("fs_bubble", 64'(id_ex_bubble), 64'h0);
        tick();
        chk("fs_addr",  64'(imem_addr),      64'h100);
        chk("fs_inst",  64'(if_id_inst),     64'h13);
        chk("fs_valid", 64'(if_id_valid),    64'h0);
        chk("fs_fcnt",  64'(flush_count),    64'h1);
        chk("fs_scnt",  64'(stall_count),    64'h1);
        chk("fs_pc",    64'(if_id_pc),       64'h8);
        chk("fs_p4",    64'(if_id_pc_plus4), 64'hC);
        stall = 1'b0; flush = 1'b0;
        tick();
        chk("tg_pc",    64'(if_id_pc),    64'h100);
        chk("tg_inst",  64'(if_id_inst),  64'h5A5A_0100);
        chk("tg_valid", 64'(if_id_valid), 64'h1);
        chk("tg_addr",  64'(imem_addr),   64'h104);

        // 5 watchdog: three consecutive stalls
        stall = 1'b1;
        tick();
        chk("wd1_err",  64'(stall_err),   64'h0);
        chk("wd1_scnt", 64'(stall_count), 64'h2);
        tick();
        chk("wd2_err",  64'(stall_err),   64'h1);
        chk("wd2_scnt", 64'(stall_count), 64'h3);
        tick();
        chk("wd3_scnt", 64'(stall_count), 64'h4);
        chk("wd3_addr", 64'(imem_addr),   64'h104);
        stall = 1'b0;
        tick();
        chk("wd_adv_pc",  64'(if_id_pc),  64'h104);
        chk("wd_adv_err", 64'(stall_err), 64'h1);
        tick();
        chk("wd_stick",   64'(stall_err), 64'h1);
        chk("wd_addr",    64'(imem_addr), 64'h10C);

        // 6a PC wrap: redirect to top of space, then advance
        flush = 1'b1; branch_target = 32'hFFFF_FFFF;
        tick();
        chk("wr_addr", 64'(imem_addr),   64'hFFFF_FFFC);
        chk("wr_fcnt", 64'(flush_count), 64'h2);
        flush = 1'b0;
        tick();
        chk("wr_pc",   64'(if_id_pc),       64'hFFFF_FFFC);
        chk("wr_p4",   64'(if_id_pc_plus4), 64'h0);
        chk("wr_inst", 64'(if_id_inst),     64'hA5A5_FFFC);
        chk("wr_next", 64'(imem_addr),      64'h0);

        // 6b reset while stall and flush are both asserted
        rst = 1'b1; stall = 1'b1; flush = 1'b1; branch_target = 32'h200;
        tick();
        chk("rs_addr",  64'(imem_addr),      64'h0);
        chk("rs_inst",  64'(if_id_inst),     64'h13);
        chk("rs_valid", 64'(if_id_valid),    64'h0);
        chk("rs_pc",    64'(if_id_pc),       64'h0);
        chk("rs_p4",    64'(if_id_pc_plus4), 64'h0);
        chk("rs_scnt",  64'(stall_count),    64'h0);
        chk("rs_fcnt",  64'(flush_count),    64'h0);
        chk("rs_err",   64'(stall_err),      64'h0);

        // 6c counter saturation on the narrow-counter instance
        rst = 1'b0; flush = 1'b0; stall = 1'b1;
        repeat (20) tick();
        chk("sat_scnt_w",  64'(stall_count),   64'd20);
        chk("sat_scnt_n",  64'(s_stall_count), 64'hF);
        chk("sat_addr",    64'(imem_addr),     64'h0);
        chk("sat_err",     64'(stall_err),     64'h1);
        stall = 1'b0; flush = 1'b1; branch_target = 32'h0;
        repeat (20) tick();
        chk("sat_fcnt_w",  64'(flush_count),   64'd20);
        chk("sat_fcnt_n",  64'(s_flush_count), 64'hF);
        chk("sat_scnt_n2", 64'(s_stall_count), 64'hF);
        flush = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
